mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
Four-requester round-robin arbiter that shares one 4:1 datapath mux between independent sources. It picks a winner, steers that source's data through the mux, and captures it in a single registered output stage with valid/ready handshake. It sits in front of any single-consumer resource fed by four producers and pairs with the team's combinational mux blocks.

Parameters:
W, 4, data width of every input and of out_data
N_REQ, 4, number of requesters; fixed at 4; select width 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  req[i]=1: requester i has data on d_i; held until gnt[i]
d0  input  W  data of requester 0
d1  input  W  data of requester 1
d2  input  W  data of requester 2
d3  input  W  data of requester 3
gnt  output  4  one-hot; gnt[i]=1: d_i is captured at this rising edge; combinational
out_valid  output  1  out_data/out_src hold a valid item
out_data  output  W  registered muxed data
out_src  output  2  index of requester that produced out_data
out_ready  input  1  consumer accepts the item when out_valid && out_ready

Behaviour:
- Reset (rst_n=0, async, no clock needed): out_valid=0, out_data=0, out_src=0, last-winner pointer=3 (first search starts at 0). gnt=0 while rst_n=0.
- Two states, encoded by out_valid: EMPTY (out_valid=0), FULL (out_valid=1).
- load = (|req) && (!out_valid || out_ready).
- Winner selection: first i with req[i]=1, searching last+1, last+2, ... modulo 4; pure combinational.
- gnt = one-hot(winner) when load, else 0. It is never multi-hot. gnt is 0 when req=0.
- On a rising edge with load=1: out_data <= d_winner (through the 4:1 mux), out_src <= winner, out_valid <= 1, last <= winner.
- On a rising edge with load=0 and out_valid && out_ready: out_valid <= 0. out_data and out_src hold their old values.
- FULL && !out_ready: out_valid, out_data and out_src are frozen, gnt=0, pointer is unchanged.
- Latency: req asserted in cycle n with stage EMPTY gives out_valid=1 in cycle n+1.
- Throughput: 1 item per cycle when out_ready=1 continuously. Simultaneous accept-and-load replaces the item with no bubble.
- Fairness: with all req held high, winners cycle 0,1,2,3,0,... No requester waits more than 3 grants.
- Pointer advances only on an actual grant. Wrap-around goes from 3 to 0.
- Requester obligation: keep req[i] and d_i stable until gnt[i]. It may deassert in the cycle after gnt[i].
- X on d_i of a non-winning requester must not affect out_data. X on out_data is allowed only if d_winner was X.
- Reset mid-operation: a pending item is discarded (out_valid=0 immediately), the pointer returns to 3 and no gnt is issued.

Optional Feature:
MUX_RR_ARBITER_FIXED_PRIO_EN
- Defined: fixed priority, req[0] highest and req[3] lowest. The last-winner pointer is not implemented. All other handshake, latency and reset rules are unchanged.
- Undefined (default): round-robin as above.

Test Plan:
- Reset: rst_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_src=0, gnt=0 immediately. The first grant after release goes to req=4'b1111 -> gnt=4'b0001.
- Single requester: req=4'b0100, d2='hc, out_ready=1 -> gnt=4'b0100 that cycle. Next cycle out_valid=1, out_data='hc, out_src=2.
- Round-robin: req=4'b1111, d0..d3='ha,'hb,'hc,'hd, out_ready=1 -> out_src 0,1,2,3,0 and out_data a,b,c,d,a on consecutive cycles.
- Backpressure: FULL with out_src=1, out_ready=0 for 3 cycles, req=4'b1101 -> gnt=0 and outputs frozen. When out_ready=1, the next item is from requester 2, with no bubble.
- Sparse/wrap: last winner=3, req=4'b1001 -> gnt=4'b0001. Then req=4'b1000 -> gnt=4'b1000. X on d1 while only req[0] is set -> out_data=d0 with no X.
- FIXED_PRIO_EN defined: req=4'b1111 held, out_ready=1 -> out_src=0 every cycle. Then req=4'b1010 -> out_src=1.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: four-requester round-robin arbiter sharing one 4:1 data mux,
// with a single registered output stage and a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request lines; req[i] and d<i> held until gnt[i]
//   d0..d3     requester data, W bits each
//   gnt[3:0]   one-hot grant (combinational); d<winner> is captured at this edge
//   out_valid  output stage holds an item (EMPTY=0 / FULL=1)
//   out_data   registered muxed data
//   out_src    index of the requester that produced out_data
//   out_ready  consumer accepts when out_valid && out_ready
//
// Build option:
//   MUX_RR_ARBITER_FIXED_PRIO_EN  defined -> fixed priority (req[0] highest),
//                                 no last-winner pointer.
//                                 undefined -> round-robin (default).
module mux_rr_arbiter #(
  parameter int W     = 4,
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic [1:0]   out_src_q,   out_src_d;

  logic [1:0]   win;
  logic         any_req;
  logic         load;
  logic [W-1:0] mux_data;

`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
  // Fixed priority: lowest index wins.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!any_req && req[k[1:0]]) begin
        win     = k[1:0];
        any_req = 1'b1;
      end
    end
  end
`else
  logic [1:0] last_q, last_d;
  logic [1:0] idx;

  // Search last+1, last+2, last+3, last (2-bit add wraps 3 -> 0).
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = last_q + k[1:0];
      if (!any_req && req[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end
`endif

  // Grant is suppressed while reset is held so no capture is ever promised.
  assign load = rst_n && any_req && (!out_valid_q || out_ready);

  always_comb begin
    gnt = '0;
    if (load) gnt[win] = 1'b1;
  end

  // Mux is indexed by the winner only, so non-winning data cannot leak in.
  always_comb begin
    case (win)
      2'd0:    mux_data = d0;
      2'd1:    mux_data = d1;
      2'd2:    mux_data = d2;
      default: mux_data = d3;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
`ifndef MUX_RR_ARBITER_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = win;
`ifndef MUX_RR_ARBITER_FIXED_PRIO_EN
      last_d      = win;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
`ifndef MUX_RR_ARBITER_FIXED_PRIO_EN
      last_q      <= 2'd3;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
`ifndef MUX_RR_ARBITER_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
